// File: rtl/and_sweep_driver.sv
// Exhaustive stimulus sweep for a WIDTH-input AND reduction, with optional
// response checking enabled by defining SWEEP_CHECK_EN.
module and_sweep_driver #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DWELL = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic             z_i,
    output logic [WIDTH-1:0] vec_o,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   err_cnt,
    output logic             fail_seen,
    output logic [WIDTH-1:0] first_fail
);

    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          launch;
    logic          sample;

    assign launch = (state != HOLD) && start && !abort;
    assign sample = (state == HOLD) && (cnt == LAST) && !abort;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            vec_o <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            vec_o <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= HOLD;
                        vec_o <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt == LAST) begin
                        // Terminal vector is detected before incrementing, so vec_o never wraps.
                        if (&vec_o) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec_o <= vec_o + 1'b1;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    vec_o <= '0;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic mismatch;
    assign mismatch = (z_i != (&vec_o));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
        end else if (launch) begin
            err_cnt    <= '0;
            fail_seen  <= 1'b0;
            first_fail <= '0;
        end else if (sample && mismatch) begin
            err_cnt <= err_cnt + 1'b1;
            if (!fail_seen) begin
                fail_seen  <= 1'b1;
                first_fail <= vec_o;
            end
        end
    end
`else
    logic unused_z;
    logic unused_ctl;
    assign unused_z   = z_i;
    assign unused_ctl = launch ^ sample;
    assign err_cnt    = '0;
    assign fail_seen  = 1'b0;
    assign first_fail = '0;
`endif

endmodule

// File: tb/tb_and_sweep_driver.sv
// Randomized bench for and_sweep_driver: a truth-table driven DUT response is
// checked against a sweep model computed directly from the truth table.
module tb_and_sweep_driver;

    localparam int W    = 2;
    localparam int D    = 10;
    localparam int TOT  = (1 << W) * D;
    localparam int W3   = 3;
    localparam int TOT3 = 1 << W3;
`ifdef SWEEP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn, start, abort, start3, abort3;
    logic [(1<<W)-1:0] tt;
    logic [7:0]        tt3;

    logic [W-1:0]  vec, ff;
    logic [W:0]    err;
    logic          busy, done, fs, z;
    logic [W3-1:0] vec3, ff3;
    logic [W3:0]   err3;
    logic          busy3, done3, fs3, z3;

    assign z  = tt[vec];
    assign z3 = tt3[vec3];

    always #5 clk = ~clk;

    and_sweep_driver #(.WIDTH(W), .DWELL(D)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort), .z_i(z),
        .vec_o(vec), .busy(busy), .done(done), .err_cnt(err),
        .fail_seen(fs), .first_fail(ff)
    );

    and_sweep_driver #(.WIDTH(W3), .DWELL(1)) u_dut3 (
        .clk(clk), .rstn(rstn), .start(start3), .abort(abort3), .z_i(z3),
        .vec_o(vec3), .busy(busy3), .done(done3), .err_cnt(err3),
        .fail_seen(fs3), .first_fail(ff3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected checker results after vectors 0..upto-1 have been sampled.
    task automatic model(input logic [15:0] tab, input int width, input int upto,
                         output int e, output int f, output int s);
        e = 0; f = 0; s = 0;
        for (int v = 0; v < upto; v++) begin
            if (CHK && (tab[v] != (v == (1 << width) - 1))) begin
                if (s == 0) f = v;
                s = 1;
                e++;
            end
        end
    endtask

    task automatic idle_check(input string tag, input int e, input int f, input int s);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_vec"}, vec, 0);
        check({tag, "_err"}, err, e);
        check({tag, "_fs"}, fs, s);
        check({tag, "_ff"}, ff, f);
    endtask

    task automatic run_sweep(input logic [3:0] t);
        int e, f, s;
        tt = t;
        model({12'b0, t}, W, 1 << W, e, f, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k <= TOT; k++) begin
            check("busy", busy, k < TOT);
            check("done", done, k == TOT);
            check("vec", vec, (k < TOT) ? k / D : (1 << W) - 1);
            if (k == 0) begin
                check("clr_err", err, 0);
                check("clr_fs", fs, 0);
                check("clr_ff", ff, 0);
            end
            if (k == TOT) begin
                check("fin_err", err, e);
                check("fin_fs", fs, s);
                check("fin_ff", ff, f);
            end
            if (k < TOT) begin
                start = ($urandom_range(0, 7) == 0);
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        repeat (2) begin
            @(posedge clk); #1;
            check("hold_done", done, 1);
            check("hold_vec", vec, (1 << W) - 1);
            check("hold_err", err, e);
        end
    endtask

    task automatic sweep3(input logic [7:0] t);
        int e, f, s;
        tt3 = t;
        model({8'b0, t}, W3, TOT3, e, f, s);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 0; k <= TOT3; k++) begin
            check("w3_busy", busy3, k < TOT3);
            check("w3_done", done3, k == TOT3);
            check("w3_vec", vec3, (k < TOT3) ? k : TOT3 - 1);
            if (k == TOT3) begin
                check("w3_err", err3, e);
                check("w3_fs", fs3, s);
                check("w3_ff", ff3, f);
            end
            if (k < TOT3) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        int e, f, s;
        rstn = 1'b0; start = 1'b0; abort = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        tt = 4'b1000; tt3 = 8'h80;
        #2;
        idle_check("rst", 0, 0, 0);
        check("rst_vec3", vec3, 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            idle_check("idle", 0, 0, 0);
        end

        run_sweep(4'b1000);                    // correct AND
        run_sweep(4'b1110);                    // OR: misses at 01 and 10
        run_sweep(4'b1110);                    // restart from DONE
        run_sweep(4'($urandom_range(0, 15)));
        run_sweep(4'($urandom_range(0, 15)));

        // abort from DONE keeps the checker results
        model(16'h000e, W, 1 << W, e, f, s);
        run_sweep(4'b1110);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        idle_check("abort_done", e, f, s);

        // start ignored mid-hold, then abort during vector 2
        tt = 4'b1110;
        model(16'h000e, W, 2, e, f, s);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2 * D + 2) @(posedge clk);
        #1;
        check("pre_abort_vec", vec, 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("ign_start_busy", busy, 1);
        check("ign_start_vec", vec, 2);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        idle_check("abort_hold", e, f, s);
        @(posedge clk); #1;
        idle_check("after_abort", e, f, s);

        sweep3(8'hff);                         // z tied high
        sweep3(8'($urandom_range(0, 255)));
        sweep3(8'h80);

        // asynchronous reset mid-sweep, away from any clock edge
        tt = 4'($urandom_range(0, 15));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (D + 3) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        idle_check("async_rst", 0, 0, 0);
        @(posedge clk); #1;
        idle_check("in_rst", 0, 0, 0);
        rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            idle_check("post_rst", 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
